// File: rtl/game_pkg.sv
// Shared types for the game speed controller: FSM encoding, speed level type
// and the saturating level step.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } game_state_t;

  localparam int MAX_LEVEL = 3;

  typedef logic [1:0] level_t;

  // Speed level never goes past MAX_LEVEL; the fastest rate is sticky.
  function automatic level_t next_level(input level_t lvl);
    return (lvl == level_t'(MAX_LEVEL)) ? lvl : lvl + level_t'(1);
  endfunction

endpackage

// File: rtl/game_speed_ctrl_if.sv
// Control/status bundle between the game logic and the speed controller.
interface game_speed_ctrl_if;
  import game_pkg::*;

  logic        start;
  logic        pause;
  logic        game_over;
  logic        tick;
  level_t      clk_rate;
  game_state_t state;
  logic        running;

  modport master (
    output start, pause, game_over,
    input  tick, clk_rate, state, running
  );

  modport slave (
    input  start, pause, game_over,
    output tick, clk_rate, state, running
  );

endinterface

// File: rtl/game_speed_ctrl_rate_counter.sv
// Terminal-count period counter with a run-time terminal value and a
// registered one-cycle wrap pulse.
module rate_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] terminal,
  output logic             wrap
);

  logic [WIDTH-1:0] count;

  // >= rather than == so a terminal that shrinks under the count still wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (en) begin
      if (count >= terminal) begin
        count <= '0;
        wrap  <= 1'b1;
      end else begin
        count <= count + WIDTH'(1);
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/game_speed_ctrl.sv
// Game speed controller: run/pause/over FSM, tick generation and a speed level
// that rises every TICKS_PER_LEVEL ticks up to level 3.
module game_speed_ctrl #(
  parameter int DIV0            = 50_000_000,
  parameter int DIV1            = 25_000_000,
  parameter int DIV2            = 12_500_000,
  parameter int DIV3            = 6_250_000,
  parameter int TICKS_PER_LEVEL = 16
) (
  input  logic             clk,
  input  logic             rst,
  game_speed_ctrl_if.slave bus
);
  import game_pkg::*;

  localparam int CNT_W = $clog2(DIV0);

  game_state_t      state_q, state_d;
  level_t           clk_rate_q;
  logic [7:0]       level_ticks_q;
  logic             tick_q;
  logic             cnt_en;
  logic             cnt_clr;
  logic             wrap;
  logic [CNT_W-1:0] terminal;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // game_over beats pause, and either one freezes the period counter.
  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        if (bus.game_over)  state_d = OVER;
        else if (bus.pause) state_d = PAUSE;
        else                cnt_en  = 1'b1;
      end
      PAUSE: begin
        if (bus.game_over)  state_d = OVER;
        else if (bus.pause) state_d = RUN;
      end
      OVER: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    terminal = CNT_W'(DIV0 - 1);
    case (clk_rate_q)
      2'd1:    terminal = CNT_W'(DIV1 - 1);
      2'd2:    terminal = CNT_W'(DIV2 - 1);
      2'd3:    terminal = CNT_W'(DIV3 - 1);
      default: terminal = CNT_W'(DIV0 - 1);
    endcase
  end

  rate_counter #(
    .WIDTH(CNT_W)
  ) u_rate_counter (
    .clk     (clk),
    .rst     (rst),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .terminal(terminal),
    .wrap    (wrap)
  );

  // The level steps on the same edge that registers the tick it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q        <= 1'b0;
      clk_rate_q    <= '0;
      level_ticks_q <= '0;
    end else begin
      tick_q <= wrap;
      if (cnt_clr) begin
        clk_rate_q    <= '0;
        level_ticks_q <= '0;
      end else if (wrap) begin
        if (level_ticks_q == 8'(TICKS_PER_LEVEL - 1)) begin
          level_ticks_q <= '0;
          clk_rate_q    <= next_level(clk_rate_q);
        end else begin
          level_ticks_q <= level_ticks_q + 8'd1;
        end
      end
    end
  end

  assign bus.tick     = tick_q;
  assign bus.clk_rate = clk_rate_q;
  assign bus.state    = state_q;
  assign bus.running  = (state_q == RUN);

endmodule

// File: tb/tb_game_speed_ctrl.sv
// Scoreboard bench for game_speed_ctrl with DIV0..3 = 8,6,4,2 and two ticks per level.
module tb_game_speed_ctrl;
  import game_pkg::*;

  typedef struct {
    int cyc;
    int rate;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  int   offs[9]  = '{9, 17, 23, 29, 33, 37, 39, 41, 43};
  int   rates[9] = '{0, 1, 1, 2, 2, 3, 3, 3, 3};

  game_speed_ctrl_if bus ();

  game_speed_ctrl #(
    .DIV0(8),
    .DIV1(6),
    .DIV2(4),
    .DIV3(2),
    .TICKS_PER_LEVEL(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic pushTick(input int at, input int rate);
    exp_t e;
    e.cyc  = at;
    e.rate = rate;
    sb.push_back(e);
  endtask

  // Drives one-cycle pulses; edge_no is the cycle index of the sampling edge.
  task automatic applyStimulus(input logic s, input logic p, input logic g, output int edge_no);
    @(negedge clk);
    bus.start     = s;
    bus.pause     = p;
    bus.game_over = g;
    @(posedge clk);
    #1;
    edge_no       = cyc;
    bus.start     = 1'b0;
    bus.pause     = 1'b0;
    bus.game_over = 1'b0;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkState(input string name, input int st, input int rate);
    checkOutput({name, "_state"}, int'(bus.state), st);
    checkOutput({name, "_running"}, int'(bus.running), (st == 1) ? 1 : 0);
    checkOutput({name, "_clk_rate"}, int'(bus.clk_rate), rate);
  endtask

  // Every tick the DUT raises must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.tick === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_tick at cycle %0d: got tick=1, required tick=0", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("tick_cycle", cyc, e.cyc);
        checkOutput("tick_clk_rate", int'(bus.clk_rate), e.rate);
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e, e0, e2, r, e3;
    bus.start     = 1'b0;
    bus.pause     = 1'b0;
    bus.game_over = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkState("reset", 0, 0);
    checkOutput("reset_tick", int'(bus.tick), 0);

    applyStimulus(1'b0, 1'b1, 1'b0, e);
    checkState("idle_pause", 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, e);
    checkState("idle_gameover", 0, 0);

    // Climb all levels: period 8, 8, 6, 6, 4, 4, then 2 forever.
    applyStimulus(1'b1, 1'b0, 1'b0, e0);
    checkState("start", 1, 0);
    for (int i = 0; i < 9; i++) pushTick(e0 + offs[i], rates[i]);

    // pause + game_over together, landing on a terminal-count cycle at level 3.
    waitUntil(e0 + 43);
    applyStimulus(1'b0, 1'b1, 1'b1, e);
    checkState("pause_and_over", 3, 3);
    repeat (5) @(posedge clk);
    #1;
    checkState("over_hold", 3, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, e);
    checkState("over_pause", 3, 3);

    applyStimulus(1'b1, 1'b0, 1'b0, e2);
    checkState("restart", 1, 0);
    pushTick(e2 + 9, 0);
    pushTick(e2 + 17, 1);
    pushTick(e2 + 44, 1);
    pushTick(e2 + 50, 2);

    // Pause with the period counter at 3 for 20 cycles.
    waitUntil(e2 + 19);
    applyStimulus(1'b0, 1'b1, 1'b0, e);
    checkState("paused", 2, 1);
    waitUntil(e2 + 39);
    checkState("still_paused", 2, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, e);
    checkState("resumed", 1, 1);

    // Pause in the terminal-count cycle at level 2 swallows the tick until resume.
    waitUntil(e2 + 52);
    applyStimulus(1'b0, 1'b1, 1'b0, e);
    checkState("tc_pause", 2, 2);
    waitUntil(e2 + 59);
    applyStimulus(1'b0, 1'b1, 1'b0, r);
    checkState("tc_resume", 1, 2);
    pushTick(r + 2, 2);

    waitUntil(r + 2);
    applyStimulus(1'b0, 1'b1, 1'b0, e);
    checkState("pause_lvl2", 2, 2);
    waitUntil(r + 6);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkState("mid_reset", 0, 0);
    checkOutput("mid_reset_tick", int'(bus.tick), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, e);
    checkState("post_reset_pause", 0, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, e3);
    checkState("start_after_reset", 1, 0);
    pushTick(e3 + 9, 0);
    waitUntil(e3 + 3);
    applyStimulus(1'b1, 1'b0, 1'b0, e);
    checkState("start_in_run", 1, 0);
    waitUntil(e3 + 10);
    applyStimulus(1'b0, 1'b0, 1'b1, e);
    checkState("final_over", 3, 0);

    repeat (6) @(posedge clk);
    #1;
    checkOutput("pending_ticks", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_speed_ctrl.md
GAME_SPEED_CTRL -- requirements
Module: game_speed_ctrl

Interface
REQ-001 Parameter DIV0, default 50_000_000; tick period in clk cycles at level 0; must be the largest DIVn.
REQ-002 Parameter DIV1, default 25_000_000; tick period at level 1.
REQ-003 Parameter DIV2, default 12_500_000; tick period at level 2.
REQ-004 Parameter DIV3, default 6_250_000; tick period at level 3; every DIVn SHALL be >= 2.
REQ-005 Parameter TICKS_PER_LEVEL, default 16; ticks per level before speed-up; range 1..256.
REQ-006 clk  input  1  single system clock; all logic on the rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 start  input  1  one-cycle pulse; begins a new game from IDLE or OVER.
REQ-009 pause  input  1  one-cycle pulse; toggles between RUN and PAUSE.
REQ-010 game_over  input  1  one-cycle pulse from game logic; ends the game.
REQ-011 tick  output  1  registered one-cycle game-step strobe.
REQ-012 clk_rate  output  2  current speed level 0..3; drives the existing clk_div rate select.
REQ-013 state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, OVER=11.
REQ-014 running  output  1  high only while state==RUN.

Function
REQ-015 States and transitions SHALL be: IDLE -start-> RUN; RUN -pause-> PAUSE; PAUSE -pause-> RUN; RUN or PAUSE -game_over-> OVER; OVER -start-> RUN. No other transitions.
REQ-016 Entering RUN from IDLE or OVER SHALL clear the period counter, the level-tick counter and clk_rate to 0.
REQ-017 start SHALL be ignored in RUN and PAUSE. pause SHALL be ignored in IDLE and OVER. game_over SHALL be ignored in IDLE and OVER.
REQ-018 Priority within one cycle: game_over > pause > period counting.
REQ-019 In RUN with no pause or game_over, the period counter SHALL increment each cycle. On reaching DIV[clk_rate]-1, it SHALL wrap to 0 and tick SHALL be 1 in the next cycle.
REQ-020 Latency: with start sampled at edge 0, the first tick SHALL be high in cycle DIV0+1. Each later tick SHALL follow DIV[clk_rate] cycles after the previous one.
REQ-021 Each tick SHALL increment the level-tick counter. When it wraps at TICKS_PER_LEVEL-1 and clk_rate<3, clk_rate SHALL increment in the same edge that emits the tick. The new period applies from the next count.
REQ-022 At clk_rate==3, clk_rate SHALL saturate; the level-tick counter keeps wrapping.
REQ-023 In PAUSE, the period counter, level-tick counter and clk_rate SHALL hold. On resume, counting SHALL continue from the held value, with no lost or extra tick.
REQ-024 A pause or game_over sampled in the terminal-count cycle SHALL suppress that tick and hold the counter at DIV-1 (pause) or let it be discarded (game_over).
REQ-025 tick SHALL be 0 in every state except the cycle after a RUN terminal count.
REQ-026 In OVER, clk_rate SHALL keep the final level for display until the next start.
REQ-027 Period counter width SHALL be $clog2(DIV0); level-tick counter width SHALL be 8 bits.

Reset
REQ-028 rst SHALL override every input and SHALL force state=IDLE, tick=0, clk_rate=0, running=0, and both counters to 0.
REQ-029 rst asserted mid-game (RUN or PAUSE) SHALL abandon the game; a later start SHALL begin at level 0.

Structure
REQ-030 A shared package game_pkg SHALL hold: the state encoding typedef (IDLE, RUN, PAUSE, OVER), MAX_LEVEL=3, and the level typedef (2 bits).
REQ-031 One sub-module, rate_counter, SHALL be used. It is a terminal-count counter with inputs en, clr and a run-time terminal value, and a registered wrap pulse. game_speed_ctrl instantiates it once and owns the FSM and level logic.

Verification (DIV0..3=8,6,4,2; TICKS_PER_LEVEL=2)
REQ-032 Reset, then start at cycle 0 -> ticks at cycles 9 and 17; clk_rate goes 0->1 with the second tick; the next tick is at cycle 23.
REQ-033 Run to level 3 -> tick period is 2 cycles; clk_rate stays 3 after further ticks.
REQ-034 Pause at period count 3, hold 20 cycles, resume -> no tick during PAUSE; the next tick arrives exactly 5 RUN cycles after resume; state reads 10, then 01.
REQ-035 pause and game_over in the same cycle during RUN -> state=OVER, tick=0, clk_rate held; a later start returns clk_rate=0 and the first tick comes DIV0+1 cycles later.
REQ-036 rst pulsed during PAUSE at level 2 -> all outputs 0 and state=IDLE next cycle; start and pause in IDLE are then ignored.
REQ-037 pause in the terminal-count cycle -> no tick emitted; after resume, the tick arrives 1 cycle later, plus the one-cycle output register.
